// File: rtl/stepper_sequencer.sv
// ---------------------------------------------------------------------------
// stepper_sequencer
//   4-coil unipolar stepper sequencer with full-step / half-step drive and a
//   signed position count. Steps come either from a synchronised external
//   STEP/DIR pair or from an internal move-to-target generator that issues
//   one step every max(period,1) clocks.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   ext_mode        : 1 = external STEP/DIR, 0 = internal target generator
//   ext_step        : async step input, rising edge = one step
//   ext_dir         : async direction, 1 = forward, 0 = reverse
//   half_step       : 1 = half-step, 0 = full-step (two-coil-on)
//   enable          : 0 = coils off, steps ignored, state held
//   period          : internal step interval in clocks (0 behaves as 1)
//   target          : signed destination, captured on target_load
//   target_load     : 1-cycle strobe
//   coils           : registered coil drive {D,C,B,A}
//   position        : signed step count (wraps silently)
//   busy            : internal move in progress
//   step_pulse      : 1-cycle strobe per applied step
//
// Internal move FSM
//   state  | meaning
//   S_IDLE | no internal move; divider held at 0
//   S_RUN  | stepping toward target_reg every max(period,1) enabled clocks
// ---------------------------------------------------------------------------
module stepper_sequencer #(
  parameter int POS_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_mode,
  input  logic             ext_step,
  input  logic             ext_dir,
  input  logic             half_step,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  input  logic [POS_W-1:0] target,
  input  logic             target_load,
  output logic [3:0]       coils,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             step_pulse
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] divider, divider_nxt, period_m1;
  logic [POS_W-1:0] target_reg, target_nxt, pos_nxt;
  logic [2:0]       phase, phase_nxt;
  logic             step_s1, step_s2, step_prev, dir_s1, dir_s2;
  logic             ext_req, int_req, int_fwd, step_do, step_fwd;
  logic [3:0]       coils_nxt;

  function automatic logic [3:0] phase_coils(input logic [2:0] ph);
    logic [3:0] c;
    case (ph)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b1100;
      3'd6:    c = 4'b1000;
      3'd7:    c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Step datapath: decide whether a step is applied this edge and where it goes.
  always_comb begin
    period_m1 = (period == '0) ? '0 : period - DIV_W'(1);
    int_fwd   = $signed(target_reg) > $signed(position);
    ext_req   = ext_mode & enable & step_s2 & ~step_prev;
    // >= rather than == so a period shortened mid-move cannot strand the divider
    int_req   = ~ext_mode & enable & (state == S_RUN) &
                (target_reg != position) & (divider >= period_m1);
    step_do   = ext_req | int_req;
    step_fwd  = ext_mode ? dir_s2 : int_fwd;
    pos_nxt   = position;
    phase_nxt = phase;
    if (step_do) begin
      pos_nxt = step_fwd ? position + POS_W'(1) : position - POS_W'(1);
      // full-step from an odd (two-coil) phase moves by 2; from an even phase by 1,
      // which realigns onto two-coil states after a half-step session
      if (!half_step && phase[0])
        phase_nxt = step_fwd ? phase + 3'd2 : phase - 3'd2;
      else
        phase_nxt = step_fwd ? phase + 3'd1 : phase - 3'd1;
    end
    coils_nxt = enable ? phase_coils(phase_nxt) : 4'b0000;
  end

  // Internal move FSM next-state.
  always_comb begin
    state_nxt   = state;
    divider_nxt = divider;
    target_nxt  = target_reg;
    if (ext_mode) begin
      // keep target_reg equal to position so leaving external mode never moves
      state_nxt   = S_IDLE;
      divider_nxt = '0;
      target_nxt  = pos_nxt;
    end else begin
      if (target_load) target_nxt = target;
      case (state)
        S_IDLE: begin
          if (target_reg != position) begin
            state_nxt   = S_RUN;
            divider_nxt = '0;
          end
        end
        S_RUN: begin
          if (target_reg == position) begin
            state_nxt   = S_IDLE;
            divider_nxt = '0;
          end else if (int_req) begin
            divider_nxt = '0;
            if (pos_nxt == target_reg) state_nxt = S_IDLE;
          end else if (enable) begin
            divider_nxt = divider + DIV_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_s1    <= 1'b0;
      step_s2    <= 1'b0;
      step_prev  <= 1'b0;
      dir_s1     <= 1'b0;
      dir_s2     <= 1'b0;
      state      <= S_IDLE;
      divider    <= '0;
      target_reg <= '0;
      phase      <= 3'd0;
      position   <= '0;
      coils      <= 4'b0000;
      step_pulse <= 1'b0;
    end else begin
      step_s1    <= ext_step;
      step_s2    <= step_s1;
      step_prev  <= step_s2;
      dir_s1     <= ext_dir;
      dir_s2     <= dir_s1;
      state      <= state_nxt;
      divider    <= divider_nxt;
      target_reg <= target_nxt;
      phase      <= phase_nxt;
      position   <= pos_nxt;
      coils      <= coils_nxt;
      step_pulse <= step_do;
    end
  end

  assign busy = (state == S_RUN);

endmodule
